fifo_stream_out: RTL
====================

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO data and stream payload.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 fifo_rd_en  output  1  read strobe to the upstream non-FWFT sync FIFO.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_valid  input  1  upstream read data valid, one cycle after fifo_rd_en.
REQ-007 fifo_dout  input  DATA_WIDTH  upstream read data, qualified by fifo_valid.
REQ-008 flush  input  1  synchronous discard of buffered and in-flight data.
REQ-009 m_valid  output  1  stream beat valid.
REQ-010 m_ready  input  1  stream consumer ready.
REQ-011 m_data  output  DATA_WIDTH  stream payload, qualified by m_valid.
REQ-012 err  output  1  sticky: fifo_valid seen with no outstanding read.
REQ-013 beat_cnt  output  16  count of accepted stream beats (m_valid && m_ready).
REQ-014 stall_cnt  output  16  count of cycles with m_valid && ~m_ready.

Function
REQ-015 Block SHALL hold a 2-entry output buffer (head/tail pointers, occupancy occ 0..2) and a 1-bit in-flight flag infl = fifo_rd_en of the previous cycle.
REQ-016 pop = m_valid && m_ready; m_valid SHALL equal (occ != 0); m_data SHALL be the head entry, driven from registers only.
REQ-017 fifo_rd_en SHALL be combinational: ~fifo_empty && ~flush && (occ + infl - pop) < 2.
REQ-018 fifo_rd_en SHALL never assert while fifo_empty is high (no upstream underflow).
REQ-019 fifo_valid && infl && ~drop SHALL write fifo_dout to tail, advance tail, increment occ; simultaneous pop SHALL leave occ unchanged.
REQ-020 Sustained throughput SHALL be one beat per cycle while upstream is non-empty and m_ready is high; first-beat latency from fifo_empty falling SHALL be 2 cycles (rd_en cycle, capture, m_valid next).
REQ-021 Buffer SHALL never overflow: the REQ-017 condition guarantees occ + infl <= 2 every cycle.
REQ-022 Pointers SHALL wrap modulo 2; order of m_data SHALL equal upstream read order.
REQ-023 flush SHALL clear occ and pointers next cycle and set drop for one cycle if infl was set; a fifo_valid in that cycle SHALL be discarded; m_valid SHALL be 0 the cycle after flush.
REQ-024 flush and pop in the same cycle: the pop completes (beat counts), the buffer still clears.
REQ-025 fifo_valid with ~infl SHALL be discarded and SHALL set err until reset; flush SHALL NOT clear err.
REQ-026 beat_cnt and stall_cnt SHALL wrap at 16'hFFFF -> 0.

Reset
REQ-027 On rst_n low: occ=0, pointers=0, infl=0, drop=0, err=0, beat_cnt=0, stall_cnt=0; hence m_valid=0, fifo_rd_en=0.
REQ-028 Reset mid-transfer SHALL discard all buffered and in-flight data; no beat SHALL appear after release until a new read returns.

Configuration
REQ-029 Macro FIFO_STREAM_OUT_STAT_EN: when defined, beat_cnt/stall_cnt counters SHALL be implemented per REQ-013/014/026.
REQ-030 When undefined, ports SHALL remain present, tied to 16'h0000, and no counter flops SHALL be inferred.

Structure
REQ-031 Shared package SHALL hold the buffer depth constant (2) and the counter width constant (16).
REQ-032 Buffer storage plus pointers SHALL be one sub-module, fifo_stream_skid_buf; issue/flush/err logic stays in the top.

Verification
REQ-033 Upstream preloaded with 8 words 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, beat_cnt=8, stall_cnt=0.
REQ-034 4 words, m_ready=0 for 10 cycles then 1 -> exactly 2 fifo_rd_en pulses during stall, occ=2, stall_cnt=10, all 4 words delivered in order.
REQ-035 Single word written while empty -> one fifo_rd_en, fifo_rd_en low on the cycle fifo_empty returns high, no upstream underflow.
REQ-036 flush asserted the cycle after a fifo_rd_en with occ=1 -> in-flight word dropped, m_valid=0 next cycle, err stays 0.
REQ-037 Force fifo_valid=1 with no prior fifo_rd_en -> err=1 next cycle and held through flush; clears only on rst_n.
REQ-038 Build without FIFO_STREAM_OUT_STAT_EN, rerun REQ-033 -> identical data, beat_cnt=stall_cnt=0.

Source files
------------

// File: rtl/fifo_stream_out_pkg.sv
// fifo_stream_out_pkg: shared constants and types for the FIFO-to-stream adapter.
// Holds the output buffer depth and the statistics counter width.
package fifo_stream_out_pkg;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    typedef logic [$clog2(BUF_DEPTH+1)-1:0] occ_t;
    typedef logic [PTR_W-1:0]               ptr_t;
endpackage

// File: rtl/fifo_stream_skid_buf.sv
// fifo_stream_skid_buf: 2-entry output buffer with head/tail pointers and occupancy.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr, din     - write din at tail
//   pop         - retire head entry
//   clear       - synchronous discard of all entries (dominates wr/pop)
//   occ         - number of valid entries (0..2)
//   dout        - head entry, straight from storage registers
module fifo_stream_skid_buf
    import fifo_stream_out_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  clear,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    ptr_t                  head;
    ptr_t                  tail;

    assign dout = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= din;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            occ <= occ + occ_t'(wr) - occ_t'(pop);
        end
    end
endmodule

// File: rtl/fifo_stream_out.sv
// fifo_stream_out: converts a non-FWFT sync FIFO read port into a valid/ready stream.
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   fifo_rd_en, fifo_empty            - upstream read strobe / empty flag
//   fifo_valid, fifo_dout             - upstream read data, one cycle after fifo_rd_en
//   flush                             - discard buffered and in-flight data
//   m_valid, m_ready, m_data          - output stream
//   err                               - sticky: upstream data arrived with no read outstanding
//   beat_cnt, stall_cnt               - accepted beats / stalled cycles (wrap at 16 bits)
// Build option: define FIFO_STREAM_OUT_STAT_EN to implement beat_cnt/stall_cnt;
// otherwise both ports read 0 and carry no flops.
module fifo_stream_out
    import fifo_stream_out_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  err,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);
    occ_t       occ;
    logic       infl;
    logic       drop;
    logic       pop;
    logic       wr;
    logic [2:0] committed;

    assign m_valid   = occ != '0;
    assign pop       = m_valid && m_ready;
    // Entries held plus the read already on its way must leave room for one more
    // word; a same-cycle pop frees a slot, so it is added to the limit instead of
    // subtracted from the count to avoid unsigned underflow.
    assign committed = {1'b0, occ} + {2'b0, infl};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush
                        && (committed < 3'(BUF_DEPTH) + {2'b0, pop});
    assign wr        = fifo_valid && infl && !drop;

    fifo_stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .din   (fifo_dout),
        .pop   (pop),
        .clear (flush),
        .occ   (occ),
        .dout  (m_data)
    );

    // drop shields the cycle after a flush that had a read outstanding, so a late
    // word is neither captured nor mistaken for an unsolicited one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl <= 1'b0;
            drop <= 1'b0;
            err  <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
            drop <= flush && infl;
            err  <= err || (fifo_valid && !infl && !drop);
        end
    end

`ifdef FIFO_STREAM_OUT_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            beat_cnt  <= beat_cnt + CNT_W'(pop);
            stall_cnt <= stall_cnt + CNT_W'(m_valid && !m_ready);
        end
    end
`else
    assign beat_cnt  = '0;
    assign stall_cnt = '0;
`endif
endmodule
